// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch. Holds the PC, issues word fetches to busio,
//            applies branch/trap redirects and drives the decode register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_redirect,
  input  logic [31:0] trap_target,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic        bus_ready,
  input  logic [31:0] bus_data,
  output logic        fetch_ready,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out
);

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_DISCARD = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;

  // PCs are word aligned, so only the word index is kept.
  logic [31:2] r_pc;
  logic [31:2] r_redirect_pc;
  logic        r_hold_valid;
  logic [31:2] r_hold_pc;
  logic [31:0] r_hold_instr;

  logic        r_valid_out;
  logic [31:0] r_pc_out;
  logic [31:0] r_instruction_out;

  logic        w_redirect;
  logic [31:2] w_target;
  logic        w_fetch_request;
  logic        w_fetch_ready;
  logic        w_fetch_accept;
  logic        w_outstanding;
  logic        w_unused_bits;

  assign w_redirect    = trap_redirect | branch_taken;
  assign w_target      = trap_redirect ? trap_target[31:2] : branch_target[31:2];
  assign w_unused_bits = ^{trap_target[1:0], branch_target[1:0]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect) begin
      w_state_nxt = w_outstanding ? S_DISCARD : S_FETCH;
    end else if ((r_state == S_DISCARD) && bus_ready) begin
      w_state_nxt = S_FETCH;
    end
  end

  // Output / handshake logic
  always_comb begin
    w_fetch_request = reset & ~r_hold_valid;
    w_fetch_accept  = (r_state == S_FETCH) & bus_ready;
    w_fetch_ready   = r_hold_valid | w_fetch_accept;
    w_outstanding   = w_fetch_request & ~bus_ready;
  end

  // PC, redirect target and hold buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_VECTOR[31:2];
      r_redirect_pc <= '0;
      r_hold_valid  <= 1'b0;
      r_hold_pc     <= '0;
      r_hold_instr  <= '0;
    end else if (w_redirect && w_outstanding) begin
      // Keep the address stable until the in-flight fetch completes.
      r_redirect_pc <= w_target;
      r_hold_valid  <= 1'b0;
    end else if (w_redirect) begin
      r_pc          <= w_target;
      r_hold_valid  <= 1'b0;
    end else if ((r_state == S_DISCARD) && bus_ready) begin
      r_pc          <= r_redirect_pc;
    end else if (w_fetch_accept) begin
      if (stall) begin
        r_hold_valid <= 1'b1;
        r_hold_pc    <= r_pc;
        r_hold_instr <= bus_data;
      end
      r_pc <= r_pc + 30'd1;
    end else if (r_hold_valid && !stall) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Fetch -> decode pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid_out       <= 1'b0;
      r_pc_out          <= RESET_VECTOR;
      r_instruction_out <= '0;
    end else if (invalidate) begin
      r_valid_out <= 1'b0;
    end else if (!stall) begin
      if (r_hold_valid) begin
        r_valid_out       <= 1'b1;
        r_pc_out          <= {r_hold_pc, 2'b00};
        r_instruction_out <= r_hold_instr;
      end else if (w_fetch_accept) begin
        r_valid_out       <= 1'b1;
        r_pc_out          <= {r_pc, 2'b00};
        r_instruction_out <= bus_data;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign fetch_request   = w_fetch_request;
  assign fetch_address   = {r_pc, 2'b00};
  assign fetch_ready     = w_fetch_ready;
  assign valid_out       = r_valid_out;
  assign pc_out          = r_pc_out;
  assign instruction_out = r_instruction_out;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed plus randomized checks of fetch_stage against a
//            queue-based reference model of the fetch rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, invalidate, branch_taken, trap_redirect, bus_ready;
  logic [31:0] branch_target, trap_target, bus_data;
  logic        fetch_request, fetch_ready, valid_out;
  logic [31:0] fetch_address, pc_out, instruction_out;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .invalidate(invalidate),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_redirect(trap_redirect), .trap_target(trap_target),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .bus_ready(bus_ready), .bus_data(bus_data), .fetch_ready(fetch_ready),
    .valid_out(valid_out), .pc_out(pc_out), .instruction_out(instruction_out)
  );

  always #5 clk = ~clk;

  // Reference model: next PC, pending discard target, hold queue, decode slot.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic [31:0] m_pc;
  bit          m_disc;
  logic [31:0] m_disc_tgt;
  ent_t        m_hold[$];
  bit          m_vo;
  logic [31:0] m_pco, m_io;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RV;
    m_disc = 0;
    m_disc_tgt = '0;
    m_hold.delete();
    m_vo = 0;
    m_pco = RV;
    m_io = '0;
  endtask

  task automatic step(input bit st, input bit inv, input bit br, input logic [31:0] bt,
                      input bit tr, input logic [31:0] tt, input bit rdy,
                      input logic [31:0] data);
    bit          req, rd, redir;
    logic [31:0] tgt;
    @(negedge clk);
    req = (m_hold.size() == 0);
    rd  = rdy && req;
    stall = st; invalidate = inv; branch_taken = br; branch_target = bt;
    trap_redirect = tr; trap_target = tt; bus_ready = rd; bus_data = data;
    #1;
    chk("fetch_request", {31'd0, fetch_request}, {31'd0, req});
    chk("fetch_address", fetch_address, m_pc);
    chk("fetch_ready", {31'd0, fetch_ready},
        {31'd0, (m_hold.size() != 0) || (!m_disc && rd)});

    redir = br || tr;
    tgt   = (tr ? tt : bt) & 32'hFFFF_FFFC;

    // Decode slot sees the state before this edge.
    if (inv) m_vo = 0;
    else if (!st) begin
      if (m_hold.size() != 0) begin
        m_vo = 1; m_pco = m_hold[0].pc; m_io = m_hold[0].ins;
      end else if (!m_disc && rd) begin
        m_vo = 1; m_pco = m_pc; m_io = data;
      end else m_vo = 0;
    end

    if (redir && req && !rd) begin
      m_disc = 1; m_disc_tgt = tgt; m_hold.delete();
    end else if (redir) begin
      m_disc = 0; m_pc = tgt; m_hold.delete();
    end else if (m_disc && rd) begin
      m_disc = 0; m_pc = m_disc_tgt;
    end else if (rd) begin
      if (st) m_hold.push_back('{pc: m_pc, ins: data});
      m_pc = m_pc + 32'd4;
    end else if (m_hold.size() != 0 && !st) begin
      void'(m_hold.pop_front());
    end

    @(posedge clk);
    #1;
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_vo});
    if (m_vo) begin
      chk("pc_out", pc_out, m_pco);
      chk("instruction_out", instruction_out, m_io);
    end
  endtask

  task automatic plain(input bit st, input bit rdy, input logic [31:0] data);
    step(st, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy, data);
  endtask

  initial begin
    reset = 1'b0; stall = 0; invalidate = 0; branch_taken = 0; trap_redirect = 0;
    branch_target = '0; trap_target = '0; bus_ready = 0; bus_data = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_request", {31'd0, fetch_request}, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_pc_out", pc_out, RV);
    chk("rst_instruction_out", instruction_out, 32'd0);
    chk("rst_fetch_address", fetch_address, RV);
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait streaming from the reset vector
    plain(0, 1, 32'hA000_0001);
    chk("stream_addr1", fetch_address, 32'h104);
    plain(0, 1, 32'hA000_0002);
    chk("stream_addr2", fetch_address, 32'h108);
    chk("stream_pc_out", pc_out, 32'h104);
    plain(0, 1, 32'hA000_0003);

    // Three wait states then completion
    repeat (3) plain(0, 0, 32'hDEAD_BEEF);
    plain(0, 1, 32'hB000_0001);

    // Stall buffering: hold, drain bubble, resume
    plain(1, 1, 32'h0010_0093);
    plain(0, 0, 32'h0);
    chk("drain_instr", instruction_out, 32'h0010_0093);
    plain(0, 1, 32'hC000_0001);

    // Branch while a fetch is outstanding
    step(0, 0, 1, 32'h200, 0, 32'h0, 0, 32'h0);
    plain(0, 0, 32'h0);
    plain(0, 1, 32'hDEAD_0001);
    chk("branch_after_discard", fetch_address, 32'h200);

    // Trap and branch together: trap wins
    step(0, 0, 1, 32'h300, 1, 32'h8000_0000, 1, 32'hE000_0001);
    chk("trap_wins", fetch_address, 32'h8000_0000);

    // PC wrap
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0, 1, 32'hE000_0002);
    chk("unaligned_target", fetch_address, 32'hFFFF_FFFC);
    plain(0, 1, 32'hE000_0003);
    chk("pc_wrap", fetch_address, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 11) == 0, $urandom,
           $urandom_range(0, 24) == 0, $urandom,
           $urandom_range(0, 9) < 6, $urandom);
    end

    // Reset while a fetch waits
    plain(0, 0, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_fetch_request", {31'd0, fetch_request}, 32'd0);
    chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("restart_addr", fetch_address, RV);
    for (int i = 0; i < 4; i++) plain(0, 1, 32'hF000_0000 + i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. Holds the program counter and issues word fetches to busio. Applies branch and trap/mret redirects, and presents the fetched instruction to decode through the fetch→decode pipeline register. Obeys `stall_fetch` and `invalidate_fetch` from the hazard unit, and produces the `fetch_ready` that the hazard unit consumes.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first PC after reset; bits [1:0] must be 0.

Ports:
- Power pins, under `USE_POWER_PINS` only:
  - `vccd1` inout 1: user area 1 1.8 V supply.
  - `vssd1` inout 1: user area 1 digital ground.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- From hazard:
  - `stall` input 1: `stall_fetch`.
  - `invalidate` input 1: `invalidate_fetch`.
- Redirect inputs:
  - `branch_taken` input 1: branch redirect from memory stage.
  - `branch_target` input 32: branch destination.
  - `trap_redirect` input 1: trap entry or mret from writeback.
  - `trap_target` input 32: trap vector or mepc.
- Bus side:
  - `fetch_request` output 1: fetch request to busio.
  - `fetch_address` output 32: word address; bits [1:0] are always 0.
  - `bus_ready` input 1: busio completes the fetch this cycle.
  - `bus_data` input 32: instruction word; valid when `bus_ready` is 1.
- `fetch_ready` output 1: instruction available this cycle (to hazard).
- To decode:
  - `valid_out` output 1: decode register holds a live instruction.
  - `pc_out` output 32: PC of that instruction.
  - `instruction_out` output 32: instruction word.

## Operation
- State machine, two states:
  - FETCH: normal operation.
  - DISCARD: an outstanding fetch whose data must be dropped.
- Registers:
  - `pc`: next address to fetch.
  - `redirect_pc`.
  - One-entry hold buffer: `hold_valid`, `hold_pc`, `hold_instr`.
  - Decode register: `valid_out`, `pc_out`, `instruction_out`.
- Combinational outputs:
  - `fetch_request` = reset deasserted && !`hold_valid`.
  - `fetch_address` = {`pc`[31:2], 2'b00}.
  - `fetch_ready` = `hold_valid` || (state==FETCH && `bus_ready`).
- Redirect:
  - `redirect` = `trap_redirect` || `branch_taken`.
  - Target is `trap_target` when `trap_redirect` is 1, else `branch_target`; trap wins when both are asserted.
  - Target bits [1:0] are ignored (forced to 0).
- Per-cycle update, first matching rule applies:
  1. `redirect`, with an outstanding fetch (`fetch_request` && !`bus_ready`): `redirect_pc` ← target, state ← DISCARD, `hold_valid` ← 0. `pc` is unchanged so `fetch_address` stays stable.
  2. `redirect`, otherwise: `pc` ← target, `hold_valid` ← 0, state ← FETCH. Any `bus_data` this cycle is dropped.
  3. DISCARD && `bus_ready`: `pc` ← `redirect_pc`, state ← FETCH, data dropped.
  4. FETCH && `bus_ready` && `stall`: `hold_pc` ← `pc`, `hold_instr` ← `bus_data`, `hold_valid` ← 1, `pc` ← `pc`+4.
  5. FETCH && `bus_ready` && !`stall`: `pc` ← `pc`+4. The data goes straight to the decode register.
  6. `hold_valid` && !`stall`: `hold_valid` ← 0. The buffer contents go to the decode register.
- In DISCARD, a further redirect overwrites `redirect_pc`; the newest redirect wins.
- Decode register, evaluated every cycle:
  - `invalidate` = 1: `valid_out` ← 0, regardless of `stall`; `pc_out`/`instruction_out` don't-care.
  - Else `stall` = 1: hold all three.
  - Else, if `hold_valid`: load {1, `hold_pc`, `hold_instr`}.
  - Else, if FETCH && `bus_ready`: load {1, `pc`, `bus_data`}.
  - Else: `valid_out` ← 0.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC + 4 → 0).

## Timing
- Reset values:
  - `pc` = `RESET_VECTOR`, state FETCH.
  - `hold_valid` = 0, `redirect_pc` = 0.
  - `valid_out` = 0, `pc_out` = `RESET_VECTOR`, `instruction_out` = 0.
  - `fetch_request` = 0 while reset is asserted.
- Reset mid-operation: all state clears immediately (asynchronous); any outstanding fetch is abandoned, and busio tolerates this.
- Bus handshake:
  - Once asserted, `fetch_request` and `fetch_address` stay stable until `bus_ready`.
  - Zero-wait-state bus: one instruction per cycle.
- Latency: address issued in cycle N with `bus_ready` in N → `valid_out`/`instruction_out` visible in N+1.
- After a redirect in cycle N:
  - No outstanding fetch: `fetch_address` = target in N+1.
  - Outstanding fetch: `fetch_address` = target in the cycle after the in-flight `bus_ready`.
- Leaving the hold buffer costs one bubble: `fetch_request` is 0 during the drain cycle and reasserts the next cycle.

## Test plan
- **Reset release**: release reset with `RESET_VECTOR`=32'h0000_0100 and a zero-wait bus → `fetch_address` sequence 0x100, 0x104, 0x108. `valid_out` is 1 from the second cycle, with `pc_out` lagging `fetch_address` by one cycle.
- **Wait states**: `bus_ready` low 3 cycles per fetch → `fetch_address` stays 0x100 for 4 cycles. `fetch_ready` is 0 for 3 of them. One valid instruction (`pc_out`=0x100) results.
- **Stall buffering**: assert `stall` in the cycle `bus_data`=32'h0010_0093 arrives → `hold_valid`=1, `fetch_request`=0, `fetch_ready`=1. Release `stall` → `instruction_out`=32'h0010_0093 and `pc_out`=0x100. The next fetch is 0x104, with no duplicate and no loss.
- **Redirect during wait states**: `branch_taken` with target 0x200 while the fetch at 0x108 is outstanding → `fetch_address` stays 0x108 until `bus_ready`, that data is dropped, and the next `fetch_address` is 0x200.
- **Simultaneous redirects**: `trap_redirect` (target 0x8000_0000) and `branch_taken` (target 0x300) in the same cycle → the next `fetch_address` is 0x8000_0000.
- **Reset mid-fetch**: assert reset while the fetch at 0x10C waits for `bus_ready` → `fetch_request`=0 and `valid_out`=0 immediately. After release, fetching restarts at `RESET_VECTOR`.
